stack_controller: RTL and testbench



---
 rtl/stacker_pkg.sv | 19 +
 rtl/stack_controller_if.sv | 36 +++
 rtl/stack_move_timer.sv | 54 +++++
 rtl/stack_controller.sv | 151 +++++++++++++++
 tb/tb_stack_controller.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stacker_pkg.sv
// Shared constants for the block-stacker sequencer: FSM state codes, datapath widths
// and direction encoding.
package stacker_pkg;

    localparam int POS_W  = 9;
    localparam int SIZE_W = 4;
    localparam int ROW_W  = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_MOVE      = 3'd1;
    localparam logic [2:0] ST_CHECK     = 3'd2;
    localparam logic [2:0] ST_NEXT      = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;
    localparam logic [2:0] ST_WIN       = 3'd5;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/stack_controller_if.sv
// Control inputs and block/row/status outputs of the stack sequencer.
// Inputs are single-cycle pulses sampled on the rising clock edge; there is no backpressure.
interface stack_controller_if;
    import stacker_pkg::*;

    logic              start;
    logic              stop_pressed;
    logic              tick;
    logic [POS_W-1:0]  curr_block_start;
    logic [POS_W-1:0]  curr_block_end;
    logic [SIZE_W-1:0] curr_block_size;
    logic [POS_W-1:0]  prev_block_start;
    logic [POS_W-1:0]  prev_block_end;
    logic [ROW_W-1:0]  row;
    logic              intersect_true;
    logic              draw_req;
    logic              playing;
    logic              game_over;
    logic              win;
    logic [2:0]        fsm_state;

    modport master (
        output start, stop_pressed, tick,
        input  curr_block_start, curr_block_end, curr_block_size,
        input  prev_block_start, prev_block_end, row,
        input  intersect_true, draw_req, playing, game_over, win, fsm_state
    );

    modport slave (
        input  start, stop_pressed, tick,
        output curr_block_start, curr_block_end, curr_block_size,
        output prev_block_start, prev_block_end, row,
        output intersect_true, draw_req, playing, game_over, win, fsm_state
    );

endinterface

// File: rtl/stack_move_timer.sv
// Divides the frame tick into one-cell move strobes. With SPEEDUP_EN defined the
// divider shrinks by one per row (floor 1), latched whenever the counter is cleared.
module stack_move_timer
    import stacker_pkg::*;
#(
    parameter int MOVE_DIV = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             enable,
    input  logic             tick,
    input  logic [ROW_W-1:0] spawn_row,
    output logic             move_en
);

    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_m1;

`ifdef SPEEDUP_EN
    logic [CNT_W-1:0] div_next_m1;

    always_comb begin
        div_next_m1 = '0;
        if (int'(spawn_row) < MOVE_DIV - 1)
            div_next_m1 = CNT_W'(MOVE_DIV - 1 - int'(spawn_row));
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            div_m1 <= CNT_W'(MOVE_DIV - 1);
        else if (clear)
            div_m1 <= div_next_m1;
    end
`else
    logic unused_spawn_row;
    assign unused_spawn_row = ^spawn_row;
    assign div_m1           = CNT_W'(MOVE_DIV - 1);
`endif

    assign move_en = enable && tick && (cnt == div_m1);

    always_ff @(posedge clock) begin
        if (!resetn)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && tick)
            cnt <= (cnt == div_m1) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/stack_controller.sv
// Block-stacker game sequencer: sweeps the current block, trims it against the previous
// row on stop, and spawns rows until win or game over. Optional macro: SPEEDUP_EN.
module stack_controller
    import stacker_pkg::*;
#(
    parameter int FIELD_W   = 160,
    parameter int UNIT_W    = 8,
    parameter int INIT_SIZE = 4,
    parameter int ROWS      = 12,
    parameter int MOVE_DIV  = 4
) (
    input  logic               clock,
    input  logic               resetn,
    stack_controller_if.slave  bus
);

    localparam int EW = POS_W + 2;
    localparam logic [POS_W-1:0]  UNIT_P   = POS_W'(UNIT_W);
    localparam logic [POS_W-1:0]  INIT_END = POS_W'(INIT_SIZE * UNIT_W - 1);
    localparam logic [SIZE_W-1:0] INIT_SZ  = SIZE_W'(INIT_SIZE);

    logic [2:0]        state;
    logic [POS_W-1:0]  curr_start, curr_end, prev_start, prev_end;
    logic [SIZE_W-1:0] curr_size;
    logic [ROW_W-1:0]  row;
    logic              intersect_true, draw_req, dir;

    logic              start_go, move_en, timer_clear;
    logic              can_right, can_left, go_right, go_left, hit;
    logic [POS_W-1:0]  ovl_start, ovl_end, spawn_end;
    logic [SIZE_W-1:0] ovl_size;
    logic [ROW_W-1:0]  row_next;

    assign start_go    = bus.start &&
                         (state == ST_IDLE || state == ST_GAME_OVER || state == ST_WIN);
    assign row_next    = row + 1'b1;
    assign timer_clear = start_go || (state == ST_NEXT);

    stack_move_timer #(.MOVE_DIV(MOVE_DIV)) u_timer (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (timer_clear),
        .enable    ((state == ST_MOVE) && !bus.stop_pressed),
        .tick      (bus.tick),
        .spawn_row ((state == ST_NEXT) ? row_next : '0),
        .move_en   (move_en)
    );

    // A blocked direction flips only if the opposite move fits; full-width blocks stay put.
    always_comb begin
        can_right = ({2'b00, curr_end} + EW'(UNIT_W)) <= EW'(FIELD_W - 1);
        can_left  = {2'b00, curr_start} >= EW'(UNIT_W);
        go_right  = (dir == DIR_RIGHT) ? can_right : (!can_left && can_right);
        go_left   = (dir == DIR_LEFT)  ? can_left  : (!can_right && can_left);
    end

    always_comb begin
        hit       = (row == '0) || ((curr_start <= prev_end) && (curr_end >= prev_start));
        ovl_start = curr_start;
        ovl_end   = curr_end;
        if (row != '0) begin
            ovl_start = (curr_start > prev_start) ? curr_start : prev_start;
            ovl_end   = (curr_end < prev_end) ? curr_end : prev_end;
        end
        ovl_size  = SIZE_W'(({2'b00, ovl_end} - {2'b00, ovl_start} + 1'b1) / EW'(UNIT_W));
        spawn_end = POS_W'(EW'(curr_size) * EW'(UNIT_W) - 1'b1);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            curr_start     <= '0;
            curr_end       <= '0;
            curr_size      <= '0;
            prev_start     <= '0;
            prev_end       <= '0;
            row            <= '0;
            intersect_true <= 1'b0;
            draw_req       <= 1'b0;
            dir            <= DIR_RIGHT;
        end else begin
            draw_req <= 1'b0;
            case (state)
                ST_IDLE, ST_GAME_OVER, ST_WIN: begin
                    if (bus.start) begin
                        curr_start <= '0;
                        curr_end   <= INIT_END;
                        curr_size  <= INIT_SZ;
                        prev_start <= '0;
                        prev_end   <= '0;
                        row        <= '0;
                        dir        <= DIR_RIGHT;
                        draw_req   <= 1'b1;
                        state      <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (bus.stop_pressed) begin
                        state <= ST_CHECK;
                    end else if (move_en && (go_right || go_left)) begin
                        dir        <= go_left ? DIR_LEFT : DIR_RIGHT;
                        curr_start <= go_right ? curr_start + UNIT_P : curr_start - UNIT_P;
                        curr_end   <= go_right ? curr_end + UNIT_P : curr_end - UNIT_P;
                        draw_req   <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    intersect_true <= hit;
                    if (hit) begin
                        curr_start <= ovl_start;
                        curr_end   <= ovl_end;
                        curr_size  <= ovl_size;
                        state      <= ST_NEXT;
                    end else begin
                        draw_req <= 1'b1;
                        state    <= ST_GAME_OVER;
                    end
                end
                ST_NEXT: begin
                    prev_start <= curr_start;
                    prev_end   <= curr_end;
                    row        <= row_next;
                    draw_req   <= 1'b1;
                    if (row_next == ROW_W'(ROWS)) begin
                        state <= ST_WIN;
                    end else begin
                        curr_start <= '0;
                        curr_end   <= spawn_end;
                        dir        <= DIR_RIGHT;
                        state      <= ST_MOVE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.curr_block_start = curr_start;
    assign bus.curr_block_end   = curr_end;
    assign bus.curr_block_size  = curr_size;
    assign bus.prev_block_start = prev_start;
    assign bus.prev_block_end   = prev_end;
    assign bus.row              = row;
    assign bus.intersect_true   = intersect_true;
    assign bus.draw_req         = draw_req;
    assign bus.playing          = (state == ST_MOVE) || (state == ST_CHECK) || (state == ST_NEXT);
    assign bus.game_over        = (state == ST_GAME_OVER);
    assign bus.win              = (state == ST_WIN);
    assign bus.fsm_state        = state;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: directed game scenarios plus random play, checked every
// cycle against a game-rule model. Build with +define+SPEEDUP_EN for the speed-up variant.
module tb_stack_controller;

  localparam int FIELD_W   = 160;
  localparam int UNIT_W    = 8;
  localparam int INIT_SIZE = 4;
  localparam int ROWS      = 3;
  localparam int MOVE_DIV  = 4;

  localparam int S_IDLE = 0, S_MOVE = 1, S_CHECK = 2, S_NEXT = 3, S_OVER = 4, S_WIN = 5;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   checking = 1'b0;

  // model of the game as the player sees it
  int m_st, m_cs, m_ce, m_sz, m_ps, m_pe, m_row, m_it, m_dr, m_dir, m_cnt;

  stack_controller_if iface();

  stack_controller #(
    .FIELD_W(FIELD_W), .UNIT_W(UNIT_W), .INIT_SIZE(INIT_SIZE),
    .ROWS(ROWS), .MOVE_DIV(MOVE_DIV)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (iface)
  );

  always #5 clock = ~clock;

  function automatic int div_for(input int r);
`ifdef SPEEDUP_EN
    return (MOVE_DIV - r < 1) ? 1 : MOVE_DIV - r;
`else
    return MOVE_DIV + 0 * r;
`endif
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clock) begin
    int w, s, e;
    bit hit, r_ok, l_ok;
    if (!resetn) begin
      m_st = S_IDLE; m_cs = 0; m_ce = 0; m_sz = 0; m_ps = 0; m_pe = 0;
      m_row = 0; m_it = 0; m_dr = 0; m_dir = 0; m_cnt = 0;
    end else begin
      m_dr = 0;
      case (m_st)
        S_IDLE, S_OVER, S_WIN: if (iface.start) begin
          m_cs = 0; m_sz = INIT_SIZE; m_ce = INIT_SIZE * UNIT_W - 1;
          m_ps = 0; m_pe = 0; m_row = 0; m_dir = 0; m_cnt = 0; m_dr = 1; m_st = S_MOVE;
        end
        S_MOVE: begin
          if (iface.stop_pressed) m_st = S_CHECK;
          else if (iface.tick) begin
            m_cnt++;
            if (m_cnt >= div_for(m_row)) begin
              m_cnt = 0;
              w = m_sz * UNIT_W;
              r_ok = (m_cs + w + UNIT_W <= FIELD_W);
              l_ok = (m_cs - UNIT_W >= 0);
              if (m_dir == 0 && !r_ok && l_ok) m_dir = 1;
              else if (m_dir == 1 && !l_ok && r_ok) m_dir = 0;
              if ((m_dir == 0 && r_ok) || (m_dir == 1 && l_ok)) begin
                m_cs += (m_dir == 0) ? UNIT_W : -UNIT_W;
                m_ce = m_cs + w - 1;
                m_dr = 1;
              end
            end
          end
        end
        S_CHECK: begin
          hit = (m_row == 0) || (m_cs <= m_pe && m_ce >= m_ps);
          m_it = hit;
          if (hit) begin
            if (m_row != 0) begin
              s = (m_cs > m_ps) ? m_cs : m_ps;
              e = (m_ce < m_pe) ? m_ce : m_pe;
              m_cs = s; m_ce = e; m_sz = (e - s + 1) / UNIT_W;
            end
            m_st = S_NEXT;
          end else begin
            m_st = S_OVER; m_dr = 1;
          end
        end
        S_NEXT: begin
          m_ps = m_cs; m_pe = m_ce; m_row++; m_dr = 1;
          if (m_row == ROWS) m_st = S_WIN;
          else begin
            m_cs = 0; m_ce = m_sz * UNIT_W - 1; m_dir = 0; m_cnt = 0; m_st = S_MOVE;
          end
        end
        default: m_st = S_IDLE;
      endcase
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("curr_start", int'(iface.curr_block_start), m_cs);
      chk("curr_end",   int'(iface.curr_block_end),   m_ce);
      chk("curr_size",  int'(iface.curr_block_size),  m_sz);
      chk("prev_start", int'(iface.prev_block_start), m_ps);
      chk("prev_end",   int'(iface.prev_block_end),   m_pe);
      chk("row",        int'(iface.row),              m_row);
      chk("intersect",  int'(iface.intersect_true),   m_it);
      chk("draw_req",   int'(iface.draw_req),         m_dr);
      chk("playing",    int'(iface.playing),   int'(m_st == S_MOVE || m_st == S_CHECK || m_st == S_NEXT));
      chk("game_over",  int'(iface.game_over), int'(m_st == S_OVER));
      chk("win",        int'(iface.win),       int'(m_st == S_WIN));
    end
  end

  task automatic cyc(input bit s, input bit sp, input bit t);
    iface.start = s;
    iface.stop_pressed = sp;
    iface.tick = t;
    @(negedge clock);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic lit_curr(input string name, input int s, input int e);
    chk({name, "_start"}, int'(iface.curr_block_start), s);
    chk({name, "_end"},   int'(iface.curr_block_end),   e);
  endtask

  initial begin
    int draws;
    iface.start = 1'b0;
    iface.stop_pressed = 1'b0;
    iface.tick = 1'b0;
    repeat (3) @(negedge clock);
    checking = 1'b1;
    chk("rst_curr_start", int'(iface.curr_block_start), 0);
    chk("rst_row", int'(iface.row), 0);
    chk("rst_playing", int'(iface.playing), 0);
    resetn = 1'b1;
    cyc(0, 0, 0);

    // start and first move
    cyc(1, 0, 0);
    lit_curr("spawn", 0, 31);
    chk("spawn_size", int'(iface.curr_block_size), 4);
    chk("spawn_playing", int'(iface.playing), 1);
    draws = 0;
    repeat (4) begin
      cyc(0, 0, 1);
      if (iface.draw_req) draws++;
    end
    chk("move_draws", draws, 1);
    lit_curr("move1", 8, 39);

    // row 0 stop at 16..47
    ticks(4);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("row0_intersect", int'(iface.intersect_true), 1);
    cyc(0, 0, 0);
    chk("row1_prev_start", int'(iface.prev_block_start), 16);
    chk("row1_prev_end", int'(iface.prev_block_end), 47);
    chk("row1_row", int'(iface.row), 1);
    lit_curr("row1_spawn", 0, 31);

    // row 1 trimmed to 32..47; divider for row 1 sets move pace
    ticks(div_for(1));
    lit_curr("row1_pace", 8, 39);
    ticks(3 * div_for(1));
    lit_curr("row1_stop", 32, 63);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    lit_curr("trim", 32, 47);
    chk("trim_size", int'(iface.curr_block_size), 2);
    cyc(0, 0, 0);
    lit_curr("row2_spawn", 0, 15);

    // row 2 aligned stop -> win
    ticks(4 * div_for(2));
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("win", int'(iface.win), 1);
    chk("win_row", int'(iface.row), 3);
    repeat (3) cyc(0, 1, 1);
    lit_curr("win_frozen", 32, 47);

    // respawn, then miss on row 1 -> game over
    cyc(1, 0, 0);
    lit_curr("respawn", 0, 31);
    ticks(8);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    ticks(8 * div_for(1));
    lit_curr("miss", 64, 95);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("miss_intersect", int'(iface.intersect_true), 0);
    chk("miss_over", int'(iface.game_over), 1);
    cyc(1, 0, 0);
    lit_curr("after_over", 0, 31);

    // bounce at the right wall, then stop beats tick
    ticks(16 * 4);
    lit_curr("wall", 128, 159);
    ticks(4);
    lit_curr("bounce", 120, 151);
    ticks(3);
    cyc(0, 1, 1);
    lit_curr("stop_beats_tick", 120, 151);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("bounce_prev", int'(iface.prev_block_start), 120);

    // random play
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        resetn = 1'b0;
        cyc(0, 0, 0);
        resetn = 1'b1;
      end else begin
        cyc($urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
      end
    end
    cyc(0, 0, 0);
    checking = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
